ad9643_spi_port: RTL and testbench

AD9643_SPI_PORT -- requirements
Module: ad9643_spi_port

---
 rtl/ad9643_spi_pkg.sv | 27 ++
 rtl/ad9643_spi_if.sv | 11 +
 rtl/ad9643_spi_port_sync_edge.sv | 58 +++++
 rtl/ad9643_spi_port.sv | 146 ++++++++++++++
 tb/tb_ad9643_spi_port.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ad9643_spi_pkg.sv
// Shared constants and types for the AD9643-style SPI register port.
package ad9643_spi_pkg;

    localparam int ADDR_W    = 13;
    localparam int MAP_DEPTH = 8192;

    localparam logic [ADDR_W-1:0] XFER_ADDR = 13'h0FF;

    localparam logic [1:0] LEN_1      = 2'b00;
    localparam logic [1:0] LEN_2      = 2'b01;
    localparam logic [1:0] LEN_3      = 2'b10;
    localparam logic [1:0] LEN_STREAM = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INSTR = 3'd1,
        ST_WR    = 3'd2,
        ST_RD    = 3'd3,
        ST_HOLD  = 3'd4
    } spi_state_t;

    // The transfer register always reads back with its self-clearing bit low.
    function automatic logic [7:0] rd_mask(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        return (a == XFER_ADDR) ? {d[7:1], 1'b0} : d;
    endfunction

endpackage

// File: rtl/ad9643_spi_if.sv
// SPI pin bundle between an external master and the register port.
interface ad9643_spi_if;
    logic csb;
    logic sclk;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output csb, output sclk, output sdi, input sdo, input sdo_oe);
    modport slave  (input csb, input sclk, input sdi, output sdo, output sdo_oe);
endinterface

// File: rtl/ad9643_spi_port_sync_edge.sv
// Brings csb/sclk/sdi into the clk domain and produces single-clk edge pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic csb,
    input  logic sclk,
    input  logic sdi,
    output logic csb_s,
    output logic csb_fall,
    output logic csb_rise,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic sdi_s
);
    logic csb_m, csb_q, csb_d;
    logic sclk_m, sclk_q, sclk_d;
    logic sdi_m, sdi_q;
    logic armed;

    assign csb_s = csb_q;

    // csb resets to low so a chip select already held low at reset release
    // cannot start a transaction until it has been seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            csb_m     <= 1'b0;
            csb_q     <= 1'b0;
            csb_d     <= 1'b0;
            sclk_m    <= 1'b0;
            sclk_q    <= 1'b0;
            sclk_d    <= 1'b0;
            sdi_m     <= 1'b0;
            sdi_q     <= 1'b0;
            sdi_s     <= 1'b0;
            armed     <= 1'b0;
            csb_fall  <= 1'b0;
            csb_rise  <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            csb_m     <= csb;
            csb_q     <= csb_m;
            csb_d     <= csb_q;
            sclk_m    <= sclk;
            sclk_q    <= sclk_m;
            sclk_d    <= sclk_q;
            sdi_m     <= sdi;
            sdi_q     <= sdi_m;
            sdi_s     <= sdi_q;
            if (csb_q) armed <= 1'b1;
            csb_fall  <= ~csb_q & csb_d & armed;
            csb_rise  <= csb_q & ~csb_d;
            sclk_rise <= sclk_q & ~sclk_d;
            sclk_fall <= ~sclk_q & sclk_d;
        end
    end

endmodule

// File: rtl/ad9643_spi_port.sv
// SPI slave with a 8192-byte register image, descending addresses and a
// self-clearing transfer bit at XFER_ADDR.
//
// state    | meaning
// IDLE     | waiting for csb fall
// INSTR    | shifting in the 16-bit instruction
// WR       | shifting in write bytes, committing each on its 8th bit
// RD       | shifting out read bytes on sdo
// HOLD     | byte count done, ignoring sclk until csb rises
module ad9643_spi_port
    import ad9643_spi_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ad9643_spi_if.slave        spi,
    output logic [7:0]         data [0:MAP_DEPTH-1],
    output logic               transfer_reg
);
    logic csb_s, csb_fall, csb_rise, sclk_rise, sclk_fall, sdi_s;

    spi_sync_edge u_sync (
        .clk       (clk),
        .reset     (reset),
        .csb       (spi.csb),
        .sclk      (spi.sclk),
        .sdi       (spi.sdi),
        .csb_s     (csb_s),
        .csb_fall  (csb_fall),
        .csb_rise  (csb_rise),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .sdi_s     (sdi_s)
    );

    spi_state_t        state;
    logic [14:0]       instr_sr;
    logic [6:0]        shift_in;
    logic [3:0]        bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        len_cnt;
    logic              stream;
    logic [7:0]        sdo_sr;
    logic              sdo_q;
    logic              xfer_req;

    logic              rise_v, fall_v, last_byte, xfer_hit;
    logic [15:0]       instr_word;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] addr_next;

    assign rise_v     = sclk_rise & ~csb_s;
    assign fall_v     = sclk_fall & ~csb_s;
    assign instr_word = {instr_sr, sdi_s};
    assign byte_in    = {shift_in, sdi_s};
    assign addr_next  = addr - 13'd1;
    assign last_byte  = ~stream && (len_cnt == 2'd0);
    assign xfer_hit   = (addr == XFER_ADDR) && byte_in[0];

    assign spi.sdo_oe = (state == ST_RD);
    assign spi.sdo    = (state == ST_RD) & sdo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data         <= '{default: 8'h00};
            state        <= ST_IDLE;
            instr_sr     <= '0;
            shift_in     <= '0;
            bit_cnt      <= '0;
            addr         <= '0;
            len_cnt      <= '0;
            stream       <= 1'b0;
            sdo_sr       <= '0;
            sdo_q        <= 1'b0;
            xfer_req     <= 1'b0;
            transfer_reg <= 1'b0;
        end else begin
            xfer_req     <= 1'b0;
            transfer_reg <= xfer_req;
            if (csb_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                sdo_q   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csb_fall) begin
                            state   <= ST_INSTR;
                            bit_cnt <= '0;
                        end
                    end
                    ST_INSTR: begin
                        if (rise_v) begin
                            instr_sr <= instr_word[14:0];
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                bit_cnt <= '0;
                                addr    <= instr_word[12:0];
                                len_cnt <= instr_word[14:13];
                                stream  <= (instr_word[14:13] == LEN_STREAM);
                                if (instr_word[15]) begin
                                    state  <= ST_RD;
                                    sdo_q  <= 1'b0;
                                    sdo_sr <= rd_mask(instr_word[12:0], data[instr_word[12:0]]);
                                end else begin
                                    state  <= ST_WR;
                                end
                            end
                        end
                    end
                    ST_WR: begin
                        if (rise_v) begin
                            shift_in <= byte_in[6:0];
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt    <= '0;
                                data[addr] <= xfer_hit ? {byte_in[7:1], 1'b0} : byte_in;
                                xfer_req   <= xfer_hit;
                                addr       <= addr_next;
                                if (last_byte) state <= ST_HOLD;
                                else if (!stream) len_cnt <= len_cnt - 2'd1;
                            end
                        end
                    end
                    ST_RD: begin
                        if (fall_v) begin
                            sdo_q  <= sdo_sr[7];
                            sdo_sr <= {sdo_sr[6:0], 1'b0};
                        end else if (rise_v) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                addr    <= addr_next;
                                sdo_sr  <= rd_mask(addr_next, data[addr_next]);
                                if (last_byte) state <= ST_HOLD;
                                else if (!stream) len_cnt <= len_cnt - 2'd1;
                            end
                        end
                    end
                    ST_HOLD: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad9643_spi_port.sv
// Scoreboard bench: drives SPI transactions and checks the register image and sdo stream.
module tb_ad9643_spi_port;
    import ad9643_spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data [0:MAP_DEPTH-1];
    logic       transfer_reg;

    ad9643_spi_if spi ();

    ad9643_spi_port dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi),
        .data         (data),
        .transfer_reg (transfer_reg)
    );

    always #5 clk = ~clk;

    localparam time HALF = 50;

    typedef struct {
        logic [12:0] a;
        logic [7:0]  v;
    } wexp_t;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] mdl [0:MAP_DEPTH-1];
    wexp_t      wq[$];
    logic       rq[$];
    int         exp_pulses = 0;
    int         pulses = 0;
    int         cyc = 0;
    int         ff_chg_cyc = -10;
    logic [7:0] ff_prev = 8'h00;
    bit         reading = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // transfer_reg must pulse exactly one clk after data[XFER_ADDR] is committed
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            ff_prev = data[XFER_ADDR];
        end else begin
            if (transfer_reg) begin
                pulses++;
                check("xfer_lat", cyc - ff_chg_cyc, 1);
            end
            if (data[XFER_ADDR] !== ff_prev) begin
                ff_chg_cyc = cyc;
                ff_prev    = data[XFER_ADDR];
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < MAP_DEPTH; i++) mdl[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic bit_io(input logic b);
        spi.sdi = b;
        #HALF;
        spi.sclk = 1'b1;
        if (reading) begin
            check("sdo_oe_rd", spi.sdo_oe, 1'b1);
            if (rq.size() > 0) check("sdo_bit", spi.sdo, rq.pop_front());
            else check("rq_size", rq.size(), 1);
        end
        #HALF;
        spi.sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_io(b[i]);
    endtask

    task automatic cs_low();
        spi.csb = 1'b0;
        #(2*HALF);
    endtask

    task automatic cs_high();
        #HALF;
        spi.csb = 1'b1;
        #(2*HALF);
    endtask

    task automatic model_write(input logic [12:0] a, input logic [7:0] v);
        if (a == XFER_ADDR && v[0]) begin
            mdl[a] = {v[7:1], 1'b0};
            exp_pulses++;
        end else begin
            mdl[a] = v;
        end
        wq.push_back('{a, mdl[a]});
    endtask

    task automatic drain();
        wexp_t e;
        while (wq.size() > 0) begin
            e = wq.pop_front();
            check($sformatf("data[%04h]", e.a), data[e.a], e.v);
        end
        check("xfer_cnt", pulses, exp_pulses);
    endtask

    task automatic spi_write(input logic [15:0] instr, input logic [31:0] payload, input int n);
        logic [12:0] a;
        logic [7:0]  b;
        a = instr[12:0];
        cs_low();
        send_byte(instr[15:8]);
        send_byte(instr[7:0]);
        for (int i = 0; i < n; i++) begin
            b = payload[31-8*i -: 8];
            send_byte(b);
            model_write(a, b);
            a = a - 13'd1;
        end
        cs_high();
        drain();
    endtask

    task automatic spi_read(input logic [15:0] instr, input int n);
        logic [12:0] a;
        logic [7:0]  v;
        a = instr[12:0];
        cs_low();
        send_byte(instr[15:8]);
        send_byte(instr[7:0]);
        for (int i = 0; i < n; i++) begin
            v = mdl[a];
            for (int k = 7; k >= 0; k--) rq.push_back(v[k]);
            a = a - 13'd1;
        end
        reading = 1'b1;
        for (int i = 0; i < n; i++) send_byte(8'h00);
        reading = 1'b0;
        #HALF;
        check("sdo_oe_hold", spi.sdo_oe, 1'b0);
        send_byte(8'hFF);
        check("sdo_oe_hold2", spi.sdo_oe, 1'b0);
        check("sdo_hold", spi.sdo, 1'b0);
        cs_high();
        check("rq_left", rq.size(), 0);
    endtask

    initial begin
        spi.csb  = 1'b0;
        spi.sclk = 1'b0;
        spi.sdi  = 1'b0;
        reset    = 1'b1;
        model_clear();
        #3;
        do_reset();
        @(negedge clk);
        check("rst_sdo", spi.sdo, 1'b0);
        check("rst_sdo_oe", spi.sdo_oe, 1'b0);
        check("rst_xfer", transfer_reg, 1'b0);
        check("rst_d000", data[0], 8'h00);
        check("rst_d0ff", data[XFER_ADDR], 8'h00);
        check("rst_d1fff", data[MAP_DEPTH-1], 8'h00);

        // csb held low through reset release must not start a transaction
        send_byte(8'h00);
        send_byte(8'h0B);
        send_byte(8'h77);
        cs_high();
        check("pre_arm_d00b", data[13'h00B], 8'h00);

        spi_write(16'h000B, 32'h05000000, 1);
        check("d00a_untouched", data[13'h00A], 8'h00);
        check("d00c_untouched", data[13'h00C], 8'h00);
        spi_write(16'h201A, 32'hABCD0000, 2);

        spi_write(16'h00FF, 32'h81000000, 1);
        spi_write(16'h00FF, 32'h02000000, 1);
        spi_write(16'h00FF, 32'h01000000, 1);
        spi_read(16'h80FF, 1);

        spi_write(16'h6000, 32'h11220000, 2);
        check("wrap_d1fff", data[MAP_DEPTH-1], 8'h22);

        spi_write(16'h000D, 32'h4C000000, 1);
        spi_read(16'h800D, 1);
        spi_read(16'hA01A, 2);

        // csb raised after 5 data bits: partial byte discarded
        cs_low();
        send_byte(8'h00);
        send_byte(8'h0B);
        for (int i = 7; i >= 3; i--) bit_io(1'b1);
        cs_high();
        check("abort_d00b", data[13'h00B], 8'h05);
        spi_write(16'h000C, 32'h3C000000, 1);
        spi_read(16'h800C, 1);

        // reset mid-byte: everything cleared, trailing bits ignored
        cs_low();
        send_byte(8'h00);
        send_byte(8'h0B);
        for (int i = 0; i < 4; i++) bit_io(1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) bit_io(1'b1);
        cs_high();
        check("rstmid_d00b", data[13'h00B], 8'h00);
        check("rstmid_d01a", data[13'h01A], 8'h00);
        check("rstmid_xfer", transfer_reg, 1'b0);
        spi_write(16'h000B, 32'h99000000, 1);
        spi_read(16'h800B, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
